// File: rtl/dec_seq_n2m.sv
// Registered N-to-2^N decoder with a loadable, up/down stepping index register.
// Stepping past either end wraps or saturates (WRAP), and either case raises a one-cycle wrap pulse.
module dec_seq_n2m #(
   parameter int N    = 2,
   parameter bit WRAP = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             e,
   input  logic             ld,
   input  logic [N-1:0]     i,
   input  logic             up,
   input  logic             dn,
   output logic [2**N-1:0]  o,
   output logic [N-1:0]     idx,
   output logic             wrap
);

   localparam logic [N-1:0] IDX_MAX = '1;
   localparam logic [N-1:0] IDX_MIN = '0;

   logic [N-1:0]    idx_q, idx_d;
   logic [2**N-1:0] o_q, o_d;
   logic            wrap_q, wrap_d;

   always_comb begin
      idx_d  = idx_q;
      wrap_d = 1'b0;
      o_d    = '0;

      if (ld) begin
         idx_d = i;
      end else if (up && !dn) begin
         if (idx_q == IDX_MAX) begin
            // A blocked step at the end is flagged just like a wrap.
            wrap_d = 1'b1;
            idx_d  = WRAP ? IDX_MIN : IDX_MAX;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else if (dn && !up) begin
         if (idx_q == IDX_MIN) begin
            wrap_d = 1'b1;
            idx_d  = WRAP ? IDX_MAX : IDX_MIN;
         end else begin
            idx_d = idx_q - 1'b1;
         end
      end

      // Decode the new index so o and idx change on the same edge.
      if (e) begin
         o_d[idx_d] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         o_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         o_q    <= o_d;
         wrap_q <= wrap_d;
      end
   end

   assign o    = o_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_seq_n2m.sv
// Bench for dec_seq_n2m: vector table on N=2/WRAP=1, hand sequences for saturation and N=4,
// then randomized N=4 traffic against an arithmetic reference model.
module tb_dec_seq_n2m;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // N=2, WRAP=1
   logic       a_rst, a_e, a_ld, a_up, a_dn, a_wrap;
   logic [1:0] a_i, a_idx;
   logic [3:0] a_o;
   // N=2, WRAP=0
   logic       s_rst, s_e, s_ld, s_up, s_dn, s_wrap;
   logic [1:0] s_i, s_idx;
   logic [3:0] s_o;
   // N=4, WRAP=1
   logic        w_rst, w_e, w_ld, w_up, w_dn, w_wrap;
   logic [3:0]  w_i, w_idx;
   logic [15:0] w_o;

   dec_seq_n2m #(.N(2), .WRAP(1'b1)) u_a (
      .clk(clk), .rst(a_rst), .e(a_e), .ld(a_ld), .i(a_i), .up(a_up), .dn(a_dn),
      .o(a_o), .idx(a_idx), .wrap(a_wrap));
   dec_seq_n2m #(.N(2), .WRAP(1'b0)) u_s (
      .clk(clk), .rst(s_rst), .e(s_e), .ld(s_ld), .i(s_i), .up(s_up), .dn(s_dn),
      .o(s_o), .idx(s_idx), .wrap(s_wrap));
   dec_seq_n2m #(.N(4), .WRAP(1'b1)) u_w (
      .clk(clk), .rst(w_rst), .e(w_e), .ld(w_ld), .i(w_i), .up(w_up), .dn(w_dn),
      .o(w_o), .idx(w_idx), .wrap(w_wrap));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       rst, e, ld;
      logic [1:0] i;
      logic       up, dn;
      logic [1:0] x_idx;
      logic [3:0] x_o;
      logic       x_wrap;
   } vec_t;

   function automatic vec_t mk(input logic rst, e, ld, input logic [1:0] i, input logic up, dn,
                               input logic [1:0] x_idx, input logic [3:0] x_o, input logic x_wrap);
      vec_t v;
      v.rst = rst; v.e = e; v.ld = ld; v.i = i; v.up = up; v.dn = dn;
      v.x_idx = x_idx; v.x_o = x_o; v.x_wrap = x_wrap;
      return v;
   endfunction

   vec_t tbl[22];

   // Reference state for the random phase.
   int m_idx;
   int r_exp_idx, r_exp_o, r_exp_wrap;

   initial begin
      //            rst e  ld i  up dn   idx o        wrap
      tbl[0]  = mk(1, 1, 1, 3, 0, 0,   0, 4'b0000, 0);
      tbl[1]  = mk(1, 1, 1, 3, 0, 0,   0, 4'b0000, 0);
      tbl[2]  = mk(0, 1, 0, 0, 0, 0,   0, 4'b0001, 0);
      tbl[3]  = mk(0, 1, 1, 0, 0, 0,   0, 4'b0001, 0);
      tbl[4]  = mk(0, 1, 1, 1, 0, 0,   1, 4'b0010, 0);
      tbl[5]  = mk(0, 1, 1, 2, 0, 0,   2, 4'b0100, 0);
      tbl[6]  = mk(0, 1, 1, 3, 0, 0,   3, 4'b1000, 0);
      tbl[7]  = mk(0, 0, 1, 0, 0, 0,   0, 4'b0000, 0);
      tbl[8]  = mk(0, 0, 1, 1, 0, 0,   1, 4'b0000, 0);
      tbl[9]  = mk(0, 0, 1, 2, 0, 0,   2, 4'b0000, 0);
      tbl[10] = mk(0, 0, 1, 3, 0, 0,   3, 4'b0000, 0);
      tbl[11] = mk(0, 1, 1, 2, 0, 0,   2, 4'b0100, 0);
      tbl[12] = mk(0, 1, 0, 0, 1, 0,   3, 4'b1000, 0);
      tbl[13] = mk(0, 1, 0, 0, 1, 0,   0, 4'b0001, 1);
      tbl[14] = mk(0, 1, 0, 0, 1, 0,   1, 4'b0010, 0);
      tbl[15] = mk(0, 1, 1, 0, 0, 0,   0, 4'b0001, 0);
      tbl[16] = mk(0, 1, 0, 0, 0, 1,   3, 4'b1000, 1);
      tbl[17] = mk(0, 1, 1, 1, 0, 0,   1, 4'b0010, 0);
      tbl[18] = mk(0, 1, 1, 3, 1, 1,   3, 4'b1000, 0);
      tbl[19] = mk(0, 1, 0, 0, 1, 1,   3, 4'b1000, 0);
      tbl[20] = mk(0, 1, 0, 0, 0, 1,   2, 4'b0100, 0);
      tbl[21] = mk(1, 1, 0, 0, 1, 0,   0, 4'b0000, 0);

      {a_rst, a_e, a_ld, a_i, a_up, a_dn} = '0;
      {s_rst, s_e, s_ld, s_i, s_up, s_dn} = '0;
      {w_rst, w_e, w_ld, w_i, w_up, w_dn} = '0;
      #1;

      for (int k = 0; k < 22; k++) begin
         a_rst = tbl[k].rst; a_e = tbl[k].e; a_ld = tbl[k].ld; a_i = tbl[k].i;
         a_up = tbl[k].up; a_dn = tbl[k].dn;
         tick();
         check($sformatf("vec%0d idx", k), 32'(a_idx), 32'(tbl[k].x_idx));
         check($sformatf("vec%0d o", k), 32'(a_o), 32'(tbl[k].x_o));
         check($sformatf("vec%0d wrap", k), 32'(a_wrap), 32'(tbl[k].x_wrap));
         $display("vec %0d: idx=%0d o=%b wrap=%0d", k, a_idx, a_o, a_wrap);
      end

      // Saturating instance: blocked steps at both ends.
      s_rst = 1'b1; s_e = 1'b1; tick(); s_rst = 1'b0;
      s_dn = 1'b1; tick(); s_dn = 1'b0;
      check("sat dn idx", 32'(s_idx), 32'd0);
      check("sat dn o", 32'(s_o), 32'b0001);
      check("sat dn wrap", 32'(s_wrap), 32'd1);
      tick();
      check("sat wrap one cycle", 32'(s_wrap), 32'd0);
      s_ld = 1'b1; s_i = 2'd3; tick(); s_ld = 1'b0;
      s_up = 1'b1; tick(); s_up = 1'b0;
      check("sat up idx", 32'(s_idx), 32'd3);
      check("sat up o", 32'(s_o), 32'b1000);
      check("sat up wrap", 32'(s_wrap), 32'd1);
      $display("sat: idx=%0d o=%b wrap=%0d", s_idx, s_o, s_wrap);

      // Wide instance: wrap from 15 to 0.
      w_rst = 1'b1; w_e = 1'b1; tick(); w_rst = 1'b0;
      w_ld = 1'b1; w_i = 4'd15; tick(); w_ld = 1'b0;
      check("n4 ld15 o", 32'(w_o), 32'h8000);
      w_up = 1'b1; tick(); w_up = 1'b0;
      check("n4 wrap idx", 32'(w_idx), 32'd0);
      check("n4 wrap o", 32'(w_o), 32'h0001);
      check("n4 wrap pulse", 32'(w_wrap), 32'd1);
      $display("n4: idx=%0d o=%h wrap=%0d", w_idx, w_o, w_wrap);

      // Random traffic on the wide instance.
      m_idx = 0;
      for (int c = 0; c < 1000; c++) begin
         w_rst = ($urandom_range(0, 49) == 0);
         w_e   = $urandom_range(0, 3) != 0;
         w_ld  = ($urandom_range(0, 7) == 0);
         w_i   = 4'($urandom_range(0, 15));
         w_up  = $urandom_range(0, 1) == 1;
         w_dn  = $urandom_range(0, 2) == 0;
         r_exp_wrap = 0;
         if (w_rst) begin
            m_idx = 0;
         end else if (w_ld) begin
            m_idx = int'(w_i);
         end else if (w_up && !w_dn) begin
            if (m_idx + 1 > 15) r_exp_wrap = 1;
            m_idx = (m_idx + 1) % 16;
         end else if (w_dn && !w_up) begin
            if (m_idx - 1 < 0) r_exp_wrap = 1;
            m_idx = (m_idx + 15) % 16;
         end
         r_exp_idx = m_idx;
         r_exp_o   = (w_e && !w_rst) ? (1 << m_idx) : 0;
         tick();
         check($sformatf("rnd%0d idx", c), 32'(w_idx), 32'(r_exp_idx));
         check($sformatf("rnd%0d o", c), 32'(w_o), 32'(r_exp_o));
         check($sformatf("rnd%0d wrap", c), 32'(w_wrap), 32'(r_exp_wrap));
         check($sformatf("rnd%0d onehot", c),
               32'(($countones(w_o) == 0) || (w_o == (16'd1 << w_idx))), 32'd1);
         $display("rnd %0d: rst=%0d e=%0d ld=%0d i=%0d up=%0d dn=%0d -> idx=%0d o=%h wrap=%0d",
                  c, w_rst, w_e, w_ld, w_i, w_up, w_dn, w_idx, w_o, w_wrap);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
